exception_ctrl: RTL and testbench

Sequences exceptions and interrupts for the 32-bit MIPS pipeline.
- Takes the decoder's illegal-instruction flag (ErrInst) and an asynchronous external interrupt line.
- Captures the faulting or interrupted PC into EPC, flushes the pipeline and redirects fetch to a vector.
- Tracks user/kernel mode and returns to EPC on Eret.
- Sits beside the main control decoder. Drives the PC mux and the pipeline-flush network.

---
 rtl/exception_ctrl_if.sv | 28 ++
 rtl/exception_ctrl.sv | 156 +++++++++++++++
 tb/tb_exception_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - pipeline-side bundle between the ID stage and the exception controller
interface exception_ctrl_if;
    logic        InstValid;
    logic        ErrInst;
    logic        Eret;
    logic [31:0] PC;
    logic        IRQ;
    logic        Flush;
    logic        Redirect;
    logic [31:0] ExcTarget;
    logic [31:0] EPC;
    logic        Supervisor;
    logic [1:0]  Cause;
    logic        Halted;
    logic [7:0]  ExcCount;

    // Pipeline / decoder side
    modport master (
        output InstValid, ErrInst, Eret, PC, IRQ,
        input  Flush, Redirect, ExcTarget, EPC, Supervisor, Cause, Halted, ExcCount
    );

    // Exception controller side
    modport slave (
        input  InstValid, ErrInst, Eret, PC, IRQ,
        output Flush, Redirect, ExcTarget, EPC, Supervisor, Cause, Halted, ExcCount
    );
endinterface

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception/interrupt sequencer: EPC capture, flush, vector redirect, mode tracking
module exception_ctrl #(
    parameter logic [31:0] ILLOP_VEC   = 32'h80000004,
    parameter logic [31:0] XADR_VEC    = 32'h80000008,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    exception_ctrl_if.slave  exc
);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ILLOP = 2'b01;
    localparam logic [1:0] CAUSE_IRQ   = 2'b10;

    typedef enum logic [2:0] {
        ST_USER   = 3'd0,
        ST_TAKE   = 3'd1,
        ST_KERNEL = 3'd2,
        ST_RET    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] irq_sync_q;
    logic                   irq_prev_q;
    logic                   irq_pend_q, irq_pend_d;
    logic [31:0]            epc_q, epc_d;
    logic [1:0]             cause_q, cause_d;
    logic                   super_q, super_d;
    logic [7:0]             exc_count_q, exc_count_d;

    logic                   irq_synced;
    logic                   irq_rise;
    logic                   take_irq;

    logic                   flush;
    logic                   redirect;
    logic [31:0]            exc_target;

    assign irq_synced = irq_sync_q[SYNC_STAGES-1];
    assign irq_rise   = irq_synced & ~irq_prev_q;

    // Shift the asynchronous IRQ level through the synchronizer and keep the previous synced value for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_sync_q <= '0;
            irq_prev_q <= 1'b0;
        end else begin
            irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], exc.IRQ};
            irq_prev_q <= irq_synced;
        end
    end

    // State and architectural registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_USER;
            irq_pend_q  <= 1'b0;
            epc_q       <= '0;
            cause_q     <= CAUSE_NONE;
            super_q     <= 1'b0;
            exc_count_q <= '0;
        end else begin
            state_q     <= state_d;
            irq_pend_q  <= irq_pend_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            super_q     <= super_d;
            exc_count_q <= exc_count_d;
        end
    end

    // Next-state logic; pending IRQs are only honoured in USER, and a fresh edge always wins over the clear
    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        super_d     = super_q;
        exc_count_d = exc_count_q;
        take_irq    = 1'b0;

        case (state_q)
            ST_USER: begin
                if (exc.InstValid && (irq_pend_q || exc.ErrInst)) begin
                    take_irq = irq_pend_q;
                    state_d  = ST_TAKE;
                    epc_d    = exc.PC;
                    cause_d  = irq_pend_q ? CAUSE_IRQ : CAUSE_ILLOP;
                    if (exc_count_q != 8'hFF) begin
                        exc_count_d = exc_count_q + 8'd1;
                    end
                end
            end
            ST_TAKE: begin
                super_d = 1'b1;
                state_d = ST_KERNEL;
            end
            ST_KERNEL: begin
                if (exc.InstValid && exc.ErrInst) begin
                    state_d = ST_HALT;
                end else if (exc.InstValid && exc.Eret) begin
                    state_d = ST_RET;
                end
            end
            ST_RET: begin
                super_d = 1'b0;
                cause_d = CAUSE_NONE;
                state_d = ST_USER;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_USER;
            end
        endcase

        irq_pend_d = irq_rise | (irq_pend_q & ~take_irq);
    end

    // Pipeline-control outputs decoded from the current state
    always_comb begin
        flush      = 1'b0;
        redirect   = 1'b0;
        exc_target = '0;
        case (state_q)
            ST_TAKE: begin
                flush      = 1'b1;
                redirect   = 1'b1;
                exc_target = (cause_q == CAUSE_IRQ) ? XADR_VEC : ILLOP_VEC;
            end
            ST_RET: begin
                flush      = 1'b1;
                redirect   = 1'b1;
                exc_target = epc_q;
            end
            ST_HALT: begin
                flush      = 1'b1;
            end
            default: begin
                flush      = 1'b0;
            end
        endcase
    end

    assign exc.Flush      = flush;
    assign exc.Redirect   = redirect;
    assign exc.ExcTarget  = exc_target;
    assign exc.EPC        = epc_q;
    assign exc.Supervisor = super_q;
    assign exc.Cause      = cause_q;
    assign exc.Halted     = (state_q == ST_HALT);
    assign exc.ExcCount   = exc_count_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl
module tb_exception_ctrl;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    exception_ctrl_if bus ();

    exception_ctrl #(
        .ILLOP_VEC   (32'h80000004),
        .XADR_VEC    (32'h80000008),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .exc   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.InstValid = 1'b0;
        bus.ErrInst   = 1'b0;
        bus.Eret      = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        bus.InstValid = 1'b0;
        bus.ErrInst   = 1'b0;
        bus.Eret      = 1'b0;
        bus.PC        = 32'h0;
        bus.IRQ       = 1'b0;

        // reset state
        step(); step();
        chk("rst_flush",    32'(bus.Flush), 32'd0);
        chk("rst_redirect", 32'(bus.Redirect), 32'd0);
        chk("rst_target",   bus.ExcTarget, 32'h0);
        chk("rst_epc",      bus.EPC, 32'h0);
        chk("rst_super",    32'(bus.Supervisor), 32'd0);
        chk("rst_cause",    32'(bus.Cause), 32'd0);
        chk("rst_halted",   32'(bus.Halted), 32'd0);
        chk("rst_count",    32'(bus.ExcCount), 32'd0);
        reset = 1'b1;

        // bubble with ErrInst: no action
        step();
        bus.ErrInst = 1'b1; bus.PC = 32'h00400000;
        step();
        chk("bubble_flush", 32'(bus.Flush), 32'd0);
        step();
        chk("bubble_count", 32'(bus.ExcCount), 32'd0);
        chk("bubble_epc",   bus.EPC, 32'h0);

        // illegal instruction
        bus.InstValid = 1'b1; bus.ErrInst = 1'b1; bus.PC = 32'h00400010;
        step();
        idle_inputs();
        chk("ill_flush",    32'(bus.Flush), 32'd1);
        chk("ill_redirect", 32'(bus.Redirect), 32'd1);
        chk("ill_target",   bus.ExcTarget, 32'h80000004);
        chk("ill_super_take", 32'(bus.Supervisor), 32'd0);
        step();
        chk("ill_epc",      bus.EPC, 32'h00400010);
        chk("ill_cause",    32'(bus.Cause), 32'd1);
        chk("ill_super",    32'(bus.Supervisor), 32'd1);
        chk("ill_count",    32'(bus.ExcCount), 32'd1);
        chk("kern_flush",   32'(bus.Flush), 32'd0);
        chk("kern_target",  bus.ExcTarget, 32'h0);

        // IRQ edge in KERNEL is masked
        bus.IRQ = 1'b1; bus.InstValid = 1'b1; bus.PC = 32'h00400014;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mask_flush", 32'(bus.Flush), 32'd0);
        end
        bus.IRQ = 1'b0;
        chk("mask_cause", 32'(bus.Cause), 32'd1);

        // return from exception
        bus.Eret = 1'b1;
        step();
        idle_inputs();
        chk("ret_redirect", 32'(bus.Redirect), 32'd1);
        chk("ret_flush",    32'(bus.Flush), 32'd1);
        chk("ret_target",   bus.ExcTarget, 32'h00400010);
        step();
        chk("ret_super",    32'(bus.Supervisor), 32'd0);
        chk("ret_cause",    32'(bus.Cause), 32'd0);
        chk("ret_flush_user", 32'(bus.Flush), 32'd0);
        step();
        chk("ret_idle_flush", 32'(bus.Flush), 32'd0);

        // first valid instruction in USER takes the pending IRQ
        bus.InstValid = 1'b1; bus.PC = 32'h00400030;
        step();
        idle_inputs();
        chk("pend_target",  bus.ExcTarget, 32'h80000008);
        chk("pend_cause",   32'(bus.Cause), 32'd2);
        chk("pend_epc",     bus.EPC, 32'h00400030);
        chk("pend_count",   32'(bus.ExcCount), 32'd2);
        step();
        bus.InstValid = 1'b1; bus.Eret = 1'b1;
        step();
        idle_inputs();
        chk("pend_ret_target", bus.ExcTarget, 32'h00400030);
        step();

        // IRQ latency: two sync flops, edge->pending, then the take
        bus.InstValid = 1'b1; bus.PC = 32'h00400020; bus.IRQ = 1'b1;
        step(); chk("irq_lat1", 32'(bus.Flush), 32'd0);
        step(); chk("irq_lat2", 32'(bus.Flush), 32'd0);
        step(); chk("irq_lat3", 32'(bus.Flush), 32'd0);
        step();
        chk("irq_flush",    32'(bus.Flush), 32'd1);
        chk("irq_target",   bus.ExcTarget, 32'h80000008);
        chk("irq_cause",    32'(bus.Cause), 32'd2);
        chk("irq_epc",      bus.EPC, 32'h00400020);
        idle_inputs();
        step();
        bus.IRQ = 1'b0;
        chk("irq_super",    32'(bus.Supervisor), 32'd1);
        bus.InstValid = 1'b1; bus.Eret = 1'b1;
        step();
        idle_inputs();
        step();
        // pending was cleared by the take: no further exception
        bus.InstValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("irq_cleared_flush", 32'(bus.Flush), 32'd0);
        end
        chk("irq_cleared_count", 32'(bus.ExcCount), 32'd3);

        // IRQ pending and ErrInst together: interrupt wins
        bus.InstValid = 1'b0; bus.IRQ = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.InstValid = 1'b1; bus.ErrInst = 1'b1; bus.PC = 32'h00400040;
        step();
        idle_inputs();
        bus.IRQ = 1'b0;
        chk("prio_cause",   32'(bus.Cause), 32'd2);
        chk("prio_target",  bus.ExcTarget, 32'h80000008);
        chk("prio_count",   32'(bus.ExcCount), 32'd4);
        step();

        // double fault in KERNEL (ErrInst beats Eret)
        bus.InstValid = 1'b1; bus.ErrInst = 1'b1; bus.Eret = 1'b1; bus.PC = 32'h00400044;
        step();
        idle_inputs();
        chk("halt_halted",   32'(bus.Halted), 32'd1);
        chk("halt_flush",    32'(bus.Flush), 32'd1);
        chk("halt_redirect", 32'(bus.Redirect), 32'd0);
        chk("halt_epc",      bus.EPC, 32'h00400040);
        for (int i = 0; i < 22; i++) begin
            step();
            chk("halt_hold", {30'd0, bus.Halted, bus.Flush}, 32'd3);
        end

        // asynchronous reset out of HALT, checked before the next clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("arst_halted", 32'(bus.Halted), 32'd0);
        chk("arst_flush",  32'(bus.Flush), 32'd0);
        chk("arst_super",  32'(bus.Supervisor), 32'd0);
        chk("arst_epc",    bus.EPC, 32'h0);
        chk("arst_count",  32'(bus.ExcCount), 32'd0);
        chk("arst_cause",  32'(bus.Cause), 32'd0);
        step();
        reset = 1'b1;
        step();

        // saturation of the exception counter
        for (int i = 0; i < 260; i++) begin
            bus.InstValid = 1'b1; bus.ErrInst = 1'b1; bus.PC = 32'h00401000;
            step();
            idle_inputs();
            step();
            bus.InstValid = 1'b1; bus.Eret = 1'b1;
            step();
            idle_inputs();
            step();
            if (i == 253) chk("sat_254", 32'(bus.ExcCount), 32'd254);
        end
        chk("sat_count", 32'(bus.ExcCount), 32'd255);
        chk("sat_super", 32'(bus.Supervisor), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
